sys_result_wb: RTL
==================

SYS_RESULT_WB -- requirements
Module: sys_result_wb

Interface
REQ-001 Parameter ROW_A, default 4, outputs per drained result vector (elements per entry).
REQ-002 Parameter OUT_WIDTH, default 32, bit width of one result element.
REQ-003 Parameter ADDR_WIDTH, default 16, result memory address width.
REQ-004 Parameter FIFO_DEPTH, default 4, buffered result vectors; power of two, >=2.
REQ-005 clk  input  1  single clock; all state on rising edge.
REQ-006 reset  input  1  asynchronous, active-low reset.
REQ-007 deload_out  input  1  result vector valid this cycle from array drain.
REQ-008 out  input  OUT_WIDTH*ROW_A  result vector; element e = bits [e*OUT_WIDTH +: OUT_WIDTH].
REQ-009 addr_res  input  ADDR_WIDTH  base address of the vector; element e goes to addr_res+e.
REQ-010 acc_en  input  1  sampled with deload_out; 1 = add to memory contents (k-tile > 0), 0 = overwrite.
REQ-011 mem_addr  output  ADDR_WIDTH  result memory address.
REQ-012 mem_re  output  1  memory read strobe; mem_rdata valid exactly one cycle later.
REQ-013 mem_rdata  input  OUT_WIDTH  memory read data.
REQ-014 mem_we  output  1  memory write strobe; memory always accepts.
REQ-015 mem_wdata  output  OUT_WIDTH  memory write data.
REQ-016 busy  output  1  high while FIFO non-empty or FSM not IDLE.
REQ-017 overflow  output  1  sticky: a vector was dropped.
REQ-018 fifo_count  output  $clog2(FIFO_DEPTH)+1  occupied FIFO entries.

Function
REQ-019 FIFO entry SHALL hold {out, addr_res, acc_en}, captured on the rising edge where deload_out=1.
REQ-020 Push when full SHALL succeed only if a pop occurs the same edge; otherwise the vector is dropped, FIFO unchanged, overflow set to 1 until reset.
REQ-021 Pop SHALL occur on the edge completing the write of element ROW_A-1 of the head entry.
REQ-022 FSM states SHALL be IDLE, RD, WR; element index e counts 0..ROW_A-1 and clears to 0 on pop.
REQ-023 IDLE -> WR when FIFO non-empty and head acc_en=0; IDLE -> RD when non-empty and acc_en=1.
REQ-024 RD: mem_re=1, mem_addr=base+e; next state WR.
REQ-025 WR: mem_we=1, mem_addr=base+e; mem_wdata = element e (acc_en=0) or element e + mem_rdata (acc_en=1), sum truncated modulo 2^OUT_WIDTH.
REQ-026 From WR with e<ROW_A-1: e+1, next state RD (acc) or WR (no acc).
REQ-027 From WR with e=ROW_A-1: pop; next state per REQ-023 on new head, else IDLE (no idle bubble between entries).
REQ-028 Throughput: ROW_A cycles per entry without accumulation, 2*ROW_A with accumulation.
REQ-029 Latency: with FIFO empty and IDLE, push at edge t SHALL give first mem_we (no acc) or mem_re (acc) in the cycle after edge t.
REQ-030 Address arithmetic base+e SHALL wrap modulo 2^ADDR_WIDTH.
REQ-031 mem_re and mem_we SHALL never be high in the same cycle; mem_addr/mem_wdata SHALL be 0 when both strobes low.
REQ-032 fifo_count SHALL be unchanged on simultaneous push and pop.

Reset
REQ-033 reset=0 SHALL immediately force state IDLE, e=0, FIFO empty, fifo_count=0, overflow=0, busy=0, mem_re=0, mem_we=0, mem_addr=0, mem_wdata=0.
REQ-034 Reset mid-drain SHALL discard all buffered vectors; no further memory strobes until a new push after release.

Verification
REQ-035 ROW_A=4, push out={4,3,2,1} (e0=1), addr_res=0x10, acc_en=0 -> writes 0x10=1, 0x11=2, 0x12=3, 0x13=4 on 4 consecutive cycles starting cycle after push; busy low afterwards.
REQ-036 Memory preloaded 0x20..0x23={10,20,30,40}, push {1,1,1,1}, acc_en=1 -> RD/WR alternation, writes 11,21,31,41, 8 cycles total.
REQ-037 Push FIFO_DEPTH+1 vectors back-to-back with first entry draining -> pop on 4th cycle frees slot, no drop, overflow=0; repeat with one extra push -> overflow=1, dropped vector never written.
REQ-038 Element 0xFFFFFFFF with acc_en=1, memory 0x00000002 -> mem_wdata=0x00000001; addr_res=0xFFFE, ROW_A=4 -> addresses 0xFFFE, 0xFFFF, 0x0000, 0x0001.
REQ-039 Assert reset after 2 of 4 writes with 2 entries buffered -> all outputs 0 immediately, fifo_count=0, no writes after release.
REQ-040 Push on the same edge the last element of head is written, FIFO full -> push accepted, fifo_count unchanged, next entry drains without bubble.

Source files
------------

// File: rtl/sys_result_wb_if.sv
// Result memory bus between the write-back drain and the result RAM.
// The RAM always accepts writes and returns read data one cycle after mem_re.
interface sys_result_wb_if #(
    parameter int ADDR_WIDTH = 16,
    parameter int OUT_WIDTH  = 32
);
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic                  mem_re;
    logic [OUT_WIDTH-1:0]  mem_rdata;
    logic                  mem_we;
    logic [OUT_WIDTH-1:0]  mem_wdata;

    modport master (
        output mem_addr,
        output mem_re,
        output mem_we,
        output mem_wdata,
        input  mem_rdata
    );

    modport slave (
        input  mem_addr,
        input  mem_re,
        input  mem_we,
        input  mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/sys_result_wb.sv
// Systolic array result write-back: buffers drained result vectors in a FIFO
// and writes them element by element, optionally accumulating into memory.
module sys_result_wb #(
    parameter int ROW_A      = 4,
    parameter int OUT_WIDTH  = 32,
    parameter int ADDR_WIDTH = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         deload_out,
    input  logic [OUT_WIDTH*ROW_A-1:0]   out,
    input  logic [ADDR_WIDTH-1:0]        addr_res,
    input  logic                         acc_en,
    sys_result_wb_if.master              mem,
    output logic                         busy,
    output logic                         overflow,
    output logic [$clog2(FIFO_DEPTH):0]  fifo_count
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int EW = (ROW_A > 1) ? $clog2(ROW_A) : 1;
    localparam logic [EW-1:0] E_LAST  = EW'(ROW_A - 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, RD, WR} state_t;

    state_t state, state_nx;
    logic [EW-1:0] e, e_nx;

    logic [OUT_WIDTH*ROW_A-1:0] q_data [FIFO_DEPTH];
    logic [ADDR_WIDTH-1:0]      q_addr [FIFO_DEPTH];
    logic                       q_acc  [FIFO_DEPTH];

    logic [PW-1:0] rd_ptr, wr_ptr;
    logic [CW-1:0] count;

    logic empty, full, pop, push, drop;
    logic [OUT_WIDTH*ROW_A-1:0] head_data;
    logic [ADDR_WIDTH-1:0]      head_addr;
    logic                       head_acc;
    logic                       next_acc;
    logic [OUT_WIDTH-1:0]       elem;
    logic [ADDR_WIDTH-1:0]      elem_addr;

    assign empty = (count == '0);
    assign full  = (count == DEPTH_C);
    assign pop   = (state == WR) && (e == E_LAST);
    // A full FIFO still takes a vector on the edge that retires the head.
    assign push  = deload_out && (!full || pop);
    assign drop  = deload_out && full && !pop;

    assign head_data = q_data[rd_ptr];
    assign head_addr = q_addr[rd_ptr];
    assign head_acc  = q_acc[rd_ptr];
    assign next_acc  = q_acc[rd_ptr + PW'(1)];
    assign elem      = head_data[int'(e)*OUT_WIDTH +: OUT_WIDTH];
    assign elem_addr = head_addr + ADDR_WIDTH'(e);

    assign busy       = !empty || (state != IDLE);
    assign fifo_count = count;

    // FIFO payload storage; contents are don't-care while unoccupied.
    always_ff @(posedge clk) begin
        if (push) begin
            q_data[wr_ptr] <= out;
            q_addr[wr_ptr] <= addr_res;
            q_acc[wr_ptr]  <= acc_en;
        end
    end

    // FIFO pointers, occupancy and sticky overflow flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (pop)
                rd_ptr <= rd_ptr + PW'(1);
            if (push)
                wr_ptr <= wr_ptr + PW'(1);
            if (push && !pop)
                count <= count + CW'(1);
            else if (pop && !push)
                count <= count - CW'(1);
            if (drop)
                overflow <= 1'b1;
        end
    end

    // Drain FSM state and element index registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            e     <= '0;
        end else begin
            state <= state_nx;
            e     <= e_nx;
        end
    end

    // Next-state: an incoming vector is started directly when nothing
    // else is queued, so neither IDLE nor a pop costs a bubble cycle.
    always_comb begin
        state_nx = state;
        e_nx     = e;
        unique case (state)
            IDLE: begin
                if (!empty)
                    state_nx = head_acc ? RD : WR;
                else if (deload_out)
                    state_nx = acc_en ? RD : WR;
            end
            RD: state_nx = WR;
            WR: begin
                if (e != E_LAST) begin
                    e_nx     = e + EW'(1);
                    state_nx = head_acc ? RD : WR;
                end else begin
                    e_nx = '0;
                    if (count > CW'(1))
                        state_nx = next_acc ? RD : WR;
                    else if (deload_out)
                        state_nx = acc_en ? RD : WR;
                    else
                        state_nx = IDLE;
                end
            end
            default: begin
                state_nx = IDLE;
                e_nx     = '0;
            end
        endcase
    end

    // Memory strobes; address and data stay zero while both strobes are low.
    always_comb begin
        mem.mem_re    = 1'b0;
        mem.mem_we    = 1'b0;
        mem.mem_addr  = '0;
        mem.mem_wdata = '0;
        unique case (state)
            RD: begin
                mem.mem_re   = 1'b1;
                mem.mem_addr = elem_addr;
            end
            WR: begin
                mem.mem_we    = 1'b1;
                mem.mem_addr  = elem_addr;
                mem.mem_wdata = head_acc ? elem + mem.mem_rdata : elem;
            end
            default: ;
        endcase
    end
endmodule
